// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-issue ALU controller with 4-entry register file
// Optional flag outputs (flag_z, flag_n) are enabled by defining ALU_ISSUE_FLAGS_EN.
module alu_issue_ctrl #(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] REG_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [1:0]        res_rd,
  output logic              err,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [1:0]        rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              res_valid_q, res_valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [1:0]        res_rd_q, res_rd_d;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];
`ifdef ALU_ISSUE_FLAGS_EN
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
`endif

  logic op_alu;
  logic op_ldi;
  logic op_wr;

  assign op_alu = (alu_op_q <= 4'd5);
  assign op_ldi = (alu_op_q == 4'hF);
  assign op_wr  = op_alu | op_ldi;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    res_valid_d = 1'b0;
    err_d       = 1'b0;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
`ifdef ALU_ISSUE_FLAGS_EN
    flag_z_d    = flag_z_q;
    flag_n_d    = flag_n_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          state_d  = S_EXEC;
          alu_a_d  = regs_q[instr[9:8]];
          alu_b_d  = regs_q[instr[7:6]];
          alu_op_d = instr[15:12];
          rd_d     = instr[11:10];
          imm_d    = DATA_W'(instr[7:0]);
        end
      end
      S_EXEC: begin
        // Result is registered here so it is presented alongside res_valid during WB.
        state_d = S_WB;
        if (op_wr) begin
          res_valid_d = 1'b1;
          res_data_d  = op_ldi ? imm_q : alu_res;
          res_rd_d    = rd_q;
`ifdef ALU_ISSUE_FLAGS_EN
          flag_z_d    = (res_data_d == '0);
          flag_n_d    = res_data_d[DATA_W-1];
`endif
        end else begin
          err_d = 1'b1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        if (res_valid_q) regs_d[rd_q] = res_data_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= REG_RST;
`ifdef ALU_ISSUE_FLAGS_EN
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
`ifdef ALU_ISSUE_FLAGS_EN
      flag_z_q    <= flag_z_d;
      flag_n_q    <= flag_n_d;
`endif
    end
  end

  // Reset arriving during WB must suppress the pulses of the aborted instruction.
  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign res_valid   = res_valid_q && !rst;
  assign err         = err_q && !rst;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;
  assign dbg_data    = regs_q[dbg_addr];
`ifdef ALU_ISSUE_FLAGS_EN
  assign flag_z      = flag_z_q;
  assign flag_n      = flag_n_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl
// Directed instructions push expected writebacks; a monitor pops and compares on each pulse.
module tb_alu_issue_ctrl;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic [3:0]        alu_op;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [1:0]        res_rd;
  logic              err;
  logic [1:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;
`ifdef ALU_ISSUE_FLAGS_EN
  logic              flag_z, flag_n;
`endif

  alu_issue_ctrl #(.DATA_W(DATA_W), .REG_RST(8'h00)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
    .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_ISSUE_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n)
`endif
  );

  always #5 clk = ~clk;

  // Combinational ALU that the controller drives.
  always_comb begin
    case (alu_op)
      4'd0:    alu_res = alu_a + alu_b;
      4'd1:    alu_res = alu_a - alu_b;
      4'd2:    alu_res = alu_a | alu_b;
      4'd3:    alu_res = alu_a & alu_b;
      4'd4:    alu_res = {7'b0, (alu_a < alu_b)};
      4'd5:    alu_res = alu_a ^ alu_b;
      default: alu_res = 8'h00;
    endcase
  end

  typedef struct {
    logic       err;
    logic [1:0] rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs, hs1, hs2, hs3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (res_valid === 1'b1 || err === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=res_valid:%0b err:%0b required=no pulse (cycle %0d)",
                 res_valid, err, cyc);
      end else begin
        e = sbq.pop_front();
        check("res_valid", {31'b0, res_valid}, {31'b0, ~e.err});
        check("err", {31'b0, err}, {31'b0, e.err});
        check("res_data", {24'b0, res_data}, {24'b0, e.data});
        check("res_rd", {30'b0, res_rd}, {30'b0, e.rd});
        check("wb_cycle", cyc, e.cyc);
      end
    end
  end

  function automatic logic [15:0] rr(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 6'b0};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {4'hF, rd, 2'b00, imm};
  endfunction

  task automatic send(input logic [15:0] w, input bit push, input logic ex_err,
                      input logic [1:0] ex_rd, input logic [7:0] ex_data,
                      input bit hold, output int hs_cyc);
    int n;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=instr_ready low required=high within 20 cycles");
      instr_valid = 1'b0;
      hs_cyc = -1;
      return;
    end
    hs_cyc = cyc;
    if (push) sbq.push_back('{ex_err, ex_rd, ex_data, hs_cyc + 2});
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      instr_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sbq.size(), 0);
  endtask

  task automatic dbg_check(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    dbg_addr = a;
    #1;
    check($sformatf("dbg_r%0d", a), {24'b0, dbg_data}, {24'b0, v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=no finish required=finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    instr = 16'h0;
    instr_valid = 1'b0;
    dbg_addr = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_in_rst", {31'b0, instr_ready}, 0);
    check("res_valid_in_rst", {31'b0, res_valid}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, instr_ready}, 1);
    check("alu_a_rst", {24'b0, alu_a}, 0);
    check("alu_b_rst", {24'b0, alu_b}, 0);
    check("alu_op_rst", {28'b0, alu_op}, 0);
    check("res_data_rst", {24'b0, res_data}, 0);
    check("res_rd_rst", {30'b0, res_rd}, 0);
    check("err_rst", {31'b0, err}, 0);
`ifdef ALU_ISSUE_FLAGS_EN
    check("flag_z_rst", {31'b0, flag_z}, 0);
    check("flag_n_rst", {31'b0, flag_n}, 0);
`endif
    for (int i = 0; i < 4; i++) dbg_check(2'(i), 8'h00);

    // Loads then dependent add.
    send(ldi(2'd1, 8'h05), 1, 0, 2'd1, 8'h05, 0, hs);
    send(ldi(2'd2, 8'h03), 1, 0, 2'd2, 8'h03, 0, hs);
    send(rr(4'd0, 2'd3, 2'd1, 2'd2), 1, 0, 2'd3, 8'h08, 0, hs);
    drain();
    dbg_check(2'd3, 8'h08);

    // Wrap, unsigned compare both directions, OR, and rd==rs1==rs2.
    send(ldi(2'd1, 8'h02), 1, 0, 2'd1, 8'h02, 0, hs);
    send(ldi(2'd2, 8'h03), 1, 0, 2'd2, 8'h03, 0, hs);
    send(rr(4'd1, 2'd0, 2'd1, 2'd2), 1, 0, 2'd0, 8'hFF, 0, hs);
    send(rr(4'd4, 2'd0, 2'd1, 2'd2), 1, 0, 2'd0, 8'h01, 0, hs);
    send(rr(4'd4, 2'd0, 2'd2, 2'd1), 1, 0, 2'd0, 8'h00, 0, hs);
    send(rr(4'd2, 2'd3, 2'd1, 2'd2), 1, 0, 2'd3, 8'h03, 0, hs);
    send(rr(4'd0, 2'd2, 2'd2, 2'd2), 1, 0, 2'd2, 8'h06, 0, hs);
    drain();
    dbg_check(2'd0, 8'h00);
    dbg_check(2'd2, 8'h06);

    // Reserved opcode: err pulse, no write, res_data/res_rd hold previous values.
    send(ldi(2'd2, 8'h55), 1, 0, 2'd2, 8'h55, 0, hs);
    send(rr(4'd7, 2'd2, 2'd1, 2'd1), 1, 1, 2'd2, 8'h55, 0, hs);
    drain();
    dbg_check(2'd2, 8'h55);

    // Back-to-back with instr_valid held high.
    send(rr(4'd0, 2'd0, 2'd2, 2'd2), 1, 0, 2'd0, 8'hAA, 1, hs1);
    send(rr(4'd5, 2'd3, 2'd0, 2'd2), 1, 0, 2'd3, 8'hFF, 1, hs2);
    send(rr(4'd3, 2'd1, 2'd3, 2'd2), 1, 0, 2'd1, 8'h55, 0, hs3);
    check("issue_gap_1", hs2 - hs1, 3);
    check("issue_gap_2", hs3 - hs2, 3);
    drain();
    dbg_check(2'd1, 8'h55);
    dbg_check(2'd3, 8'hFF);

`ifdef ALU_ISSUE_FLAGS_EN
    send(rr(4'd5, 2'd1, 2'd1, 2'd1), 1, 0, 2'd1, 8'h00, 0, hs);
    drain();
    check("flag_z_xor", {31'b0, flag_z}, 1);
    check("flag_n_xor", {31'b0, flag_n}, 0);
    send(ldi(2'd2, 8'h80), 1, 0, 2'd2, 8'h80, 0, hs);
    drain();
    check("flag_z_ldi", {31'b0, flag_z}, 0);
    check("flag_n_ldi", {31'b0, flag_n}, 1);
`endif

    // Reset during EXEC aborts the instruction and clears the register file.
    send(ldi(2'd1, 8'h10), 1, 0, 2'd1, 8'h10, 0, hs);
    drain();
    send(rr(4'd0, 2'd1, 2'd1, 2'd1), 0, 0, 2'd1, 8'h20, 0, hs);
    rst = 1'b1;
    @(negedge clk);
    check("ready_mid_rst", {31'b0, instr_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", {31'b0, instr_ready}, 1);
    for (int i = 0; i < 4; i++) dbg_check(2'(i), 8'h00);
    repeat (4) @(negedge clk);

    send(ldi(2'd0, 8'h7E), 1, 0, 2'd0, 8'h7E, 0, hs);
    drain();
    dbg_check(2'd0, 8'h7E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the 8-bit ALU interface: accepts 16-bit instruction words over a valid/ready handshake, reads operands from a local 4x8 register file, drives ALU operands and opcode, captures the ALU result and writes it back.
- Sits between the instruction source (test sequencer / future fetch unit) and the combinational ALU.
- Issues one instruction at a time.

Parameters:
- DATA_W, 8, operand/result width; must equal the ALU data width.
- REG_RST, 0, reset value loaded into every register file entry.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  16  instruction word; sampled when instr_valid && instr_ready.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  controller can accept; high only in IDLE.
- alu_a  out  DATA_W  operand A to ALU, registered.
- alu_b  out  DATA_W  operand B to ALU, registered.
- alu_op  out  4  function select to ALU, registered.
- alu_res  in  DATA_W  combinational ALU result.
- res_valid  out  1  one-cycle pulse on writeback.
- res_data  out  DATA_W  written value; held until next writeback.
- res_rd  out  2  destination index of last writeback.
- err  out  1  one-cycle pulse when a reserved opcode retires.
- dbg_addr  in  2  register file debug read index.
- dbg_data  out  DATA_W  regfile[dbg_addr], combinational.

Behaviour:
- Instruction format: op=[15:12], rd=[11:10], rs1=[9:8], rs2=[7:6], imm=[7:0] (LDI only); unused bits ignored.
- Opcodes: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 SLTU (result 1/0), 5 XOR are ALU ops. 6..14 are reserved. 15 is LDI (rd <= imm; ALU not used).
- FSM states: IDLE -> EXEC -> WB -> IDLE. No other transitions except reset.
- IDLE: instr_ready=1. On handshake, latch the decoded fields and load alu_a=reg[rs1], alu_b=reg[rs2], alu_op=op. Go to EXEC.
- EXEC: instr_ready=0. ALU inputs are stable for the whole cycle. Capture alu_res into the result register. Go to WB.
- WB:
  - ALU op: reg[rd]<=captured result; res_valid=1, res_data=result, res_rd=rd.
  - LDI: reg[rd]<=imm; res_valid=1, res_data=imm.
  - Reserved op: no regfile write, res_valid=0, err=1; res_data/res_rd unchanged.
  - Go to IDLE.
- Latency: handshake at cycle T -> res_valid at T+2 -> instr_ready high at T+3. Throughput is 1 instruction per 3 cycles.
- Register read happens at handshake. An instruction reading the rd of the previous instruction therefore sees the written value, because that write completed in WB before IDLE.
- instr_valid while busy: ignored (ready=0). The source must hold instr stable until the handshake.
- rs1==rs2==rd is legal. Operands are read before the write.
- Arithmetic is modulo 2^DATA_W (the ALU wraps). SLTU is unsigned.
- All four registers, including index 0, are writable.
- Reset values: FSM=IDLE, instr_ready=1 in the cycle after reset deasserts (0 while rst is high), alu_a=0, alu_b=0, alu_op=0, res_valid=0, res_data=0, res_rd=0, err=0, every reg=REG_RST.
- Reset mid-operation (EXEC or WB): aborts the instruction; no writeback, no res_valid, no err.
- dbg_data reflects a write starting the cycle after WB.

Optional Feature:
- Macro ALU_ISSUE_FLAGS_EN.
- Defined:
  - Adds outputs flag_z (1) and flag_n (1), reset to 0.
  - Updated in WB of any writing instruction (ALU op or LDI): flag_z = (res==0), flag_n = res[DATA_W-1].
  - Unchanged on reserved ops.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- LDI r1,0x05; LDI r2,0x03; ADD r3=r1+r2 -> res_valid 2 cycles after each handshake; res_data 0x05, 0x03, then 0x08 with res_rd=3; dbg_addr=3 reads 0x08.
- r1=0x02, r2=0x03: SUB r0=r1-r2 -> 0xFF (wrap); SLTU r0=r1<r2 -> 0x01; SLTU r0=r2<r1 -> 0x00.
- Opcode 7 with rd=2, r2=0x55 -> err pulses at T+2, res_valid stays 0, r2 remains 0x55.
- instr_valid held high continuously with 3 queued instructions -> instr_ready high only every 3rd cycle; exactly 3 res_valid pulses; no instruction dropped or duplicated.
- rst asserted in EXEC of ADD r1=r1+r1 (r1=0x10) -> no res_valid; all regs = REG_RST; instr_ready=1 the cycle after rst drops.
- With ALU_ISSUE_FLAGS_EN: XOR r1=r1^r1 -> flag_z=1, flag_n=0; LDI r2,0x80 -> flag_z=0, flag_n=1.
